// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;
  localparam int BEAT_CNT_W     = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                found,
  output logic [ID_WIDTH-1:0] index
);

  // cand[k] is the requester at distance k+1 from last_grant
  logic [ID_WIDTH-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_WIDTH'((int'(last_grant) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Scan farthest to nearest so the nearest hit is the one kept
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        index = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic [BEAT_CNT_W-1:0]         beat_count
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_t          state_reg;
  logic [ID_WIDTH-1:0] last_grant_reg;
  logic [ID_WIDTH-1:0] grant_id_reg;
  logic [BW-1:0]       burst_cnt_reg;
  logic [BEAT_CNT_W-1:0] beat_count_reg;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                cur_valid;
  logic                cur_last;
  logic                accept;
  logic                burst_done;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .found      (pick_found),
    .index      (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = accept && (grant_id_reg == ID_WIDTH'(gi));
    end
  endgenerate

  assign cur_valid  = req_valid[grant_id_reg];
  assign cur_last   = req_last[grant_id_reg];
  // Full is checked in the same cycle, so a deasserting full accepts immediately
  assign accept     = (state_reg == BURST) && cur_valid && !fifo_full;
  assign burst_done = cur_last || (burst_cnt_reg == BW'(MAX_BURST - 1));

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = data_arr[grant_id_reg];
  assign grant_id     = grant_id_reg;
  assign busy         = (state_reg == BURST);
  assign beat_count   = beat_count_reg;

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      burst_cnt_reg  <= '0;
      beat_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_id_reg  <= pick_idx;
            burst_cnt_reg <= '0;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_count_reg <= beat_count_reg + BEAT_CNT_W'(1);
            burst_cnt_reg  <= burst_cnt_reg + BW'(1);
            if (burst_done) begin
              state_reg      <= IDLE;
              last_grant_reg <= grant_id_reg;
            end
          end else if (!cur_valid) begin
            // Requester withdrew: give up the port without writing
            state_reg      <= IDLE;
            last_grant_reg <= grant_id_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: main instance (MAX_BURST=4) plus a MAX_BURST=16 instance for beat_count wrap.
module tb_fifo_wr_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          wr_clk = 1'b0;
  logic          wr_rstn;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic          fifo_full, fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic [15:0]   beat_count;

  logic          b_rstn;
  logic [NR-1:0] b_valid, b_last, b_ready;
  logic [NR*DW-1:0] b_data;
  logic          b_full, b_wr_en;
  logic [DW-1:0] b_wr_data;
  logic [IW-1:0] b_grant;
  logic          b_busy;
  logic [15:0]   b_beat_count;

  int total = 0;
  int bad   = 0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
    .busy(busy), .beat_count(beat_count)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(16)) dut_wrap (
    .wr_clk(wr_clk), .wr_rstn(b_rstn), .req_valid(b_valid), .req_last(b_last),
    .req_data(b_data), .req_ready(b_ready), .fifo_full(b_full),
    .fifo_wr_en(b_wr_en), .fifo_wr_data(b_wr_data), .grant_id(b_grant),
    .busy(b_busy), .beat_count(b_beat_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge wr_clk);
  endtask

  task automatic check_beat(input string tag, input int id, input logic [DW-1:0] d);
    check_val({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd1);
    check_val({tag, "_grant"}, 32'(grant_id), 32'(id));
    check_val({tag, "_data"}, 32'(fifo_wr_data), 32'(d));
    check_val({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    step();
    wr_rstn = 1'b0;
    #1;
    step();
    wr_rstn = 1'b1;
  endtask

  task automatic main_seq();
    wr_rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    step();
    #1;
    check_idle("rst");
    check_val("rst_grant", 32'(grant_id), 32'd0);
    check_val("rst_beats", 32'(beat_count), 32'd0);
    step();
    wr_rstn = 1'b1;

    // single-beat packet from requester 0
    step();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 16'h0003;
    #1;
    check_idle("t1_bubble");
    step(); #1;
    check_beat("t1_beat", 0, 4'h3);
    step();
    req_valid = '0; req_last = '0;
    #1;
    check_idle("t1_done");
    check_val("t1_beats", 32'(beat_count), 32'd1);

    // all four valid, no last: 0,1,2,3,0 with 4 beats each
    do_reset();
    req_valid = 4'b1111; req_last = 4'b0000; req_data = 16'h7654;
    for (int g = 0; g < 5; g++) begin
      #1;
      check_idle($sformatf("t2_bub%0d", g));
      if (g == 4) check_val("t2_beats16", 32'(beat_count), 32'd16);
      for (int b = 0; b < 4; b++) begin
        step(); #1;
        check_beat($sformatf("t2_g%0d_b%0d", g, b), g % 4, 4'(4 + (g % 4)));
      end
      step();
    end
    #1;
    check_val("t2_beats20", 32'(beat_count), 32'd20);
    req_valid = '0;

    // requester 2 stalled by full for 5 cycles mid-burst
    step();
    req_valid = 4'b0100; req_data = 16'h0900;
    #1;
    check_idle("t3_bubble");
    for (int b = 0; b < 2; b++) begin
      step(); #1;
      check_beat($sformatf("t3_b%0d", b), 2, 4'h9);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      fifo_full = 1'b1;
      #1;
      check_val($sformatf("t3_full%0d_wr_en", c), 32'(fifo_wr_en), 32'd0);
      check_val($sformatf("t3_full%0d_ready", c), 32'(req_ready), 32'd0);
      check_val($sformatf("t3_full%0d_grant", c), 32'(grant_id), 32'd2);
      check_val($sformatf("t3_full%0d_busy", c), 32'(busy), 32'd1);
    end
    for (int b = 2; b < 4; b++) begin
      step();
      fifo_full = 1'b0;
      #1;
      check_beat($sformatf("t3_b%0d", b), 2, 4'h9);
    end
    step();
    req_valid = '0;
    #1;
    check_idle("t3_done");
    check_val("t3_beats", 32'(beat_count), 32'd24);

    // requester 1 releases after 2 beats, requester 3 waiting
    step();
    req_valid = 4'b0010; req_data = 16'hA0B0;
    #1;
    check_idle("t4_bubble");
    step(); #1;
    check_beat("t4_b0", 1, 4'hB);
    step();
    req_valid = 4'b1010;
    #1;
    check_beat("t4_b1", 1, 4'hB);
    step();
    req_valid = 4'b1000; req_last = 4'b1000;
    #1;
    check_val("t4_rel_wr_en", 32'(fifo_wr_en), 32'd0);
    check_val("t4_rel_busy", 32'(busy), 32'd1);
    check_val("t4_rel_ready", 32'(req_ready), 32'd0);
    step(); #1;
    check_idle("t4_bubble2");
    step(); #1;
    check_beat("t4_r3", 3, 4'hA);
    step();
    req_valid = '0; req_last = '0;
    #1;
    check_idle("t4_done");
    check_val("t4_beats", 32'(beat_count), 32'd27);

    // asynchronous reset during beat 3
    step();
    req_valid = 4'b0001; req_data = 16'h000C;
    for (int b = 0; b < 3; b++) begin
      step(); #1;
      check_beat($sformatf("t5_b%0d", b), 0, 4'hC);
    end
    #1;
    wr_rstn = 1'b0;
    #1;
    check_idle("t5_rst");
    check_val("t5_rst_grant", 32'(grant_id), 32'd0);
    check_val("t5_rst_beats", 32'(beat_count), 32'd0);
    step();
    wr_rstn = 1'b1;
    req_valid = 4'b1111; req_data = 16'h4321; req_last = 4'b1111;
    step(); #1;
    check_beat("t5_after", 0, 4'h1);
    step();
    req_valid = '0; req_last = '0;
    #1;
    check_val("t5_beats", 32'(beat_count), 32'd1);
  endtask

  task automatic wrap_seq();
    int cnt;
    int cyc;
    b_rstn = 1'b0; b_valid = '0; b_last = '0; b_data = 16'h1111; b_full = 1'b0;
    step();
    step();
    b_rstn = 1'b1;
    b_valid = 4'b1111;
    cnt = 0;
    cyc = 0;
    while (cnt < 65536 && cyc < 80000) begin
      step(); #1;
      cyc++;
      if (b_wr_en) cnt++;
    end
    check_val("wrap_reached", 32'(cnt), 32'd65536);
    check_val("wrap_pre", 32'(b_beat_count), 32'd65535);
    step();
    b_valid = '0;
    #1;
    check_val("wrap_post", 32'(b_beat_count), 32'd0);
  endtask

  initial begin
    fork
      main_seq();
      wrap_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the wr_clk domain. Grants the port round-robin, holds the grant for a burst of up to MAX_BURST beats or until the requester marks its last beat, and never asserts a write while the FIFO reports full. Sits directly in front of the FIFO write interface (wr_data / wr_en / full).

## Interface
- DATA_WIDTH, 4: FIFO word width.
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 4: maximum beats per grant, 1..16.
- ID_WIDTH, clog2(NUM_REQ): width of grant_id.
- wr_clk  in  1  write-domain clock; all logic rising-edge.
- wr_rstn  in  1  reset: asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last beat of packet, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed requester data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accept.
- fifo_full  in  1  FIFO full flag (wr_clk domain).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- grant_id  out  ID_WIDTH  current grant owner; valid while busy=1.
- busy  out  1  state is BURST.
- beat_count  out  16  total beats written since reset; wraps 0xFFFF -> 0.

## Operation
- States: IDLE, BURST.
- IDLE: if any req_valid, select first requester with req_valid set searching from (last_grant+1) mod NUM_REQ upward, wrapping; register grant_id, clear burst counter, go BURST. No req_valid: stay IDLE.
- BURST: beat accepted when req_valid[grant_id] && !fifo_full. On accept: fifo_wr_en=1, fifo_wr_data=req_data[grant_id], req_ready[grant_id]=1, burst counter +1, beat_count +1.
- BURST exit to IDLE (last_grant <= grant_id) on the edge after: accepted beat with req_last[grant_id]=1, or accepted beat with burst counter == MAX_BURST-1, or req_valid[grant_id]=0 in a cycle (voluntary release, no beat).
- fifo_full=1 in BURST: no beat, counter and state held; grant retained indefinitely while requester keeps req_valid.
- req_ready[i]=0 for all i != grant_id, and for all i in IDLE.
- fifo_wr_en equals req_ready[grant_id] && req_valid[grant_id]; never 1 when fifo_full=1.
- Burst counter width clog2(MAX_BURST)+1; no wrap inside a burst.

## Timing
- Reset values: state IDLE, last_grant NUM_REQ-1 (requester 0 first), grant_id 0, busy 0, beat_count 0, burst counter 0; fifo_wr_en 0, req_ready all 0.
- fifo_wr_en, req_ready, fifo_wr_data combinational from registered state/grant and current req_valid, fifo_full; zero-cycle accept in BURST.
- Arbitration bubble: request seen in IDLE at edge t -> BURST from t, first beat can be accepted in cycle following edge t (one idle cycle per grant switch).
- Back-to-back packets from the same sole requester: one bubble cycle between grants.
- fifo_full sampled combinationally each cycle; deassertion allows accept in the same cycle.
- Reset mid-burst: immediate return to reset values; partially sent packet abandoned; beats already written remain in FIFO.
- Simultaneous req_last and MAX_BURST limit on one beat: single exit, no double count.

## Structure
- Package fifo_arb_pkg: state enum {IDLE, BURST}, default DATA_WIDTH/NUM_REQ/MAX_BURST constants, beat_count width constant 16.
- Sub-module rr_pick: combinational round-robin picker (inputs req vector, last_grant; outputs found, index). Everything else in fifo_wr_arbiter.

## Test plan
- Reset, req_valid=4'b0001, data 0x3, req_last=1, fifo_full=0 -> one bubble cycle, then fifo_wr_en=1 with fifo_wr_data=0x3, grant_id=0, return to IDLE, beat_count=1.
- All four requesters valid continuously, req_last=0, MAX_BURST=4 -> grants 0,1,2,3,0 in order, exactly 4 beats each, one bubble between grants, beat_count=16 after four grants.
- Requester 2 in BURST, fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 those cycles, grant_id stays 2, burst resumes and totals 4 beats.
- Requester 1 sends 2 beats then drops req_valid while requester 3 valid -> grant released after 2 beats, next grant to 3.
- wr_rstn asserted for one cycle during beat 3 of a burst -> all outputs at reset values asynchronously, next grant starts with requester 0 (if valid), beat_count=0.
- beat_count preloaded by 65535 accepted beats, one more beat -> beat_count wraps to 0.
